// File: rtl/disp_pkg.sv
// Shared constants for the output display driver.
// Holds the FSM state encoding, the 7-segment glyph table and the sizing constants.
package disp_pkg;

   localparam int unsigned NumDigits  = 3;
   localparam int unsigned DataWidth  = 8;
   localparam int unsigned BcdWidth   = 4 * NumDigits;
   localparam int unsigned ShiftWidth = BcdWidth + DataWidth;

   typedef logic [1:0] state_t;
   localparam state_t StIdle    = 2'd0;
   localparam state_t StConvert = 2'd1;
   localparam state_t StCommit  = 2'd2;

   // Segments are {g,f,e,d,c,b,a}, active high.
   localparam logic [6:0] GLYPH_BLANK = 7'h00;
   localparam logic [6:0] GLYPH_TABLE [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

endpackage

// File: rtl/out_display_driver_if.sv
// Bus between the CPU output register and the display driver.
//   master: CPU side, drives out_valid/out_data/dec_mode, observes status and pins.
//   slave : driver side, drives busy/bcd/seg/dig_sel.
interface out_display_driver_if;

   logic        out_valid;
   logic [7:0]  out_data;
   logic        dec_mode;
   logic        busy;
   logic [11:0] bcd;
   logic [6:0]  seg;
   logic [2:0]  dig_sel;

   modport master (
      output out_valid, out_data, dec_mode,
      input  busy, bcd, seg, dig_sel
   );

   modport slave (
      input  out_valid, out_data, dec_mode,
      output busy, bcd, seg, dig_sel
   );

endinterface

// File: rtl/bcd_dabble8.sv
// Sequential shift-add-3 binary-to-BCD engine for one 8-bit value.
//   clk_i, rst_n : clock, async active-low reset
//   load_i       : load {12'b0, data_i} and clear the step counter
//   step_i       : perform one add-3/shift step
//   last_o       : the current step is the final (8th) one
//   shift_o      : shift register; [19:8] hold the BCD result after 8 steps
module bcd_dabble8
   import disp_pkg::*;
(
   input  logic                  clk_i,
   input  logic                  rst_n,
   input  logic                  load_i,
   input  logic [DataWidth-1:0]  data_i,
   input  logic                  step_i,
   output logic                  last_o,
   output logic [ShiftWidth-1:0] shift_o
);

   logic [ShiftWidth-1:0] shift_q, shift_d, adj;
   logic [2:0]            cnt_q, cnt_d;

   always_comb begin
      // Per-nibble correction; nibbles never exceed 9 so no carry can leave a nibble.
      adj = shift_q;
      for (int i = 0; i < NumDigits; i++) begin
         if (shift_q[DataWidth + 4*i +: 4] >= 4'd5) begin
            adj[DataWidth + 4*i +: 4] = shift_q[DataWidth + 4*i +: 4] + 4'd3;
         end
      end

      shift_d = shift_q;
      cnt_d   = cnt_q;
      if (load_i) begin
         shift_d = {{BcdWidth{1'b0}}, data_i};
         cnt_d   = '0;
      end else if (step_i) begin
         shift_d = {adj[ShiftWidth-2:0], 1'b0};
         cnt_d   = cnt_q + 3'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         shift_q <= '0;
         cnt_q   <= '0;
      end else begin
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
      end
   end

   assign last_o  = step_i && (cnt_q == 3'd7);
   assign shift_o = shift_q;

endmodule

// File: rtl/out_display_driver.sv
// Captures CPU output values, converts to BCD (decimal) or passes hex nibbles,
// and scans the result onto a 3-digit multiplexed 7-segment display.
//   clkin, rst_n : clock, async active-low reset
//   bus          : out_valid/out_data/dec_mode in; busy/bcd/seg/dig_sel out
module out_display_driver
   import disp_pkg::*;
#(
   parameter int unsigned SCAN_DIV = 4,
   parameter int unsigned BLANK_LZ = 1
) (
   input  logic                clkin,
   input  logic                rst_n,
   out_display_driver_if.slave bus
);

   localparam int unsigned PrescW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam bit          BlankLz = (BLANK_LZ != 0);

   state_t                 state_q, state_d;
   logic                   mode_q, mode_d;
   logic                   pend_vld_q, pend_vld_d;
   logic [DataWidth-1:0]   pend_data_q, pend_data_d;
   logic                   pend_mode_q, pend_mode_d;
   logic [BcdWidth-1:0]    bcd_q, bcd_d;
   logic                   cmode_q, cmode_d;
   logic [PrescW-1:0]      presc_q, presc_d;
   logic [1:0]             idx_q, idx_d;
   logic [NumDigits-1:0]   dig_sel_q, dig_sel_d;
   logic [6:0]             seg_q, seg_d;

   logic                   capture, cap_mode, last;
   logic [DataWidth-1:0]   cap_data;
   logic [ShiftWidth-1:0]  shift;

   bcd_dabble8 u_dabble (
      .clk_i   (clkin),
      .rst_n   (rst_n),
      .load_i  (capture),
      .data_i  (cap_data),
      .step_i  (state_q == StConvert),
      .last_o  (last),
      .shift_o (shift)
   );

   always_comb begin
      state_d     = state_q;
      mode_d      = mode_q;
      pend_vld_d  = pend_vld_q;
      pend_data_d = pend_data_q;
      pend_mode_d = pend_mode_q;
      bcd_d       = bcd_q;
      cmode_d     = cmode_q;
      capture     = 1'b0;
      cap_data    = bus.out_data;
      cap_mode    = bus.dec_mode;

      case (state_q)
         StIdle: begin
            if (bus.out_valid) capture = 1'b1;
         end
         StConvert: begin
            if (last) state_d = StCommit;
            if (bus.out_valid) begin
               pend_vld_d  = 1'b1;
               pend_data_d = bus.out_data;
               pend_mode_d = bus.dec_mode;
            end
         end
         StCommit: begin
            bcd_d      = mode_q ? shift[ShiftWidth-1:DataWidth] : {4'h0, shift[DataWidth-1:0]};
            cmode_d    = mode_q;
            state_d    = StIdle;
            pend_vld_d = 1'b0;
            // A live strobe beats the pending slot; either way the slot is consumed.
            if (bus.out_valid) begin
               capture = 1'b1;
            end else if (pend_vld_q) begin
               capture  = 1'b1;
               cap_data = pend_data_q;
               cap_mode = pend_mode_q;
            end
         end
         default: state_d = StIdle;
      endcase

      if (capture) begin
         mode_d  = cap_mode;
         state_d = cap_mode ? StConvert : StCommit;
      end
   end

   // Display scanner: outputs are registered from the current index, so a digit
   // change lags the index by one cycle while still holding SCAN_DIV cycles.
   logic       wrap, blank_sel, d2_zero, d1_zero;
   logic [3:0] digit;

   always_comb begin
      wrap    = (presc_q == PrescW'(SCAN_DIV - 1));
      presc_d = wrap ? '0 : presc_q + PrescW'(1);
      idx_d   = idx_q;
      if (wrap) idx_d = (idx_q == 2'(NumDigits - 1)) ? 2'd0 : idx_q + 2'd1;

      d2_zero = (bcd_q[11:8] == 4'h0);
      d1_zero = (bcd_q[7:4] == 4'h0);

      digit     = bcd_q[3:0];
      blank_sel = 1'b0;
      dig_sel_d = 3'b001;
      case (idx_q)
         2'd1: begin
            digit     = bcd_q[7:4];
            blank_sel = cmode_q && BlankLz && d2_zero && d1_zero;
            dig_sel_d = 3'b010;
         end
         2'd2: begin
            digit     = bcd_q[11:8];
            blank_sel = cmode_q ? (BlankLz && d2_zero) : 1'b1;
            dig_sel_d = 3'b100;
         end
         default: ;
      endcase
      seg_d = blank_sel ? GLYPH_BLANK : GLYPH_TABLE[digit];
   end

   always_ff @(posedge clkin or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         mode_q      <= 1'b0;
         pend_vld_q  <= 1'b0;
         pend_data_q <= '0;
         pend_mode_q <= 1'b0;
         bcd_q       <= '0;
         cmode_q     <= 1'b1;
         presc_q     <= '0;
         idx_q       <= '0;
         dig_sel_q   <= '0;
         seg_q       <= '0;
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         pend_vld_q  <= pend_vld_d;
         pend_data_q <= pend_data_d;
         pend_mode_q <= pend_mode_d;
         bcd_q       <= bcd_d;
         cmode_q     <= cmode_d;
         presc_q     <= presc_d;
         idx_q       <= idx_d;
         dig_sel_q   <= dig_sel_d;
         seg_q       <= seg_d;
      end
   end

   assign bus.busy    = (state_q != StIdle);
   assign bus.bcd     = bcd_q;
   assign bus.seg     = seg_q;
   assign bus.dig_sel = dig_sel_q;

endmodule

// File: tb/tb_out_display_driver.sv
// Directed self-checking bench for out_display_driver.
// u_dut uses SCAN_DIV=4, BLANK_LZ=1; u_dut0 uses SCAN_DIV=1, BLANK_LZ=0 on the same inputs.
module tb_out_display_driver;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   n_cmp  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   out_display_driver_if bus ();
   out_display_driver_if bus0 ();

   assign bus0.out_valid = bus.out_valid;
   assign bus0.out_data  = bus.out_data;
   assign bus0.dec_mode  = bus.dec_mode;

   out_display_driver #(.SCAN_DIV(4), .BLANK_LZ(1)) u_dut (
      .clkin (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   out_display_driver #(.SCAN_DIV(1), .BLANK_LZ(0)) u_dut0 (
      .clkin (clk),
      .rst_n (rst_n),
      .bus   (bus0)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [7:0] d, input logic dec);
      bus.out_valid = v;
      bus.out_data  = d;
      bus.dec_mode  = dec;
   endtask

   // Called just after an edge; the value is captured at the next edge (edge 0).
   task automatic strobe(input logic [7:0] d, input logic dec);
      drive(1'b1, d, dec);
      tick();
      drive(1'b0, 8'h00, 1'b0);
   endtask

   // Step until the chosen instance selects digit 'sel', then check its glyph.
   task automatic check_digit(input string tag, input bit which, input logic [2:0] sel,
                              input logic [6:0] exp);
      logic [2:0] cur;
      cur = 3'b000;
      for (int i = 0; i < 16; i++) begin
         tick();
         cur = which ? bus0.dig_sel : bus.dig_sel;
         if (cur == sel) break;
      end
      check({tag, "_sel"}, 32'(cur), 32'(sel));
      check({tag, "_seg"}, 32'(which ? bus0.seg : bus.seg), 32'(exp));
   endtask

   initial begin
      int n;
      drive(1'b0, 8'h00, 1'b0);
      #1 rst_n = 1'b0;
      #2;
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_bcd", 32'(bus.bcd), 32'h000);
      check("rst_seg", 32'(bus.seg), 32'h00);
      check("rst_sel", 32'(bus.dig_sel), 32'd0);
      #9 rst_n = 1'b1;
      tick();
      check("post_rst_sel", 32'(bus.dig_sel), 32'b001);
      check("post_rst_seg", 32'(bus.seg), 32'h3F);
      check("post_rst_sel0", 32'(bus0.dig_sel), 32'b001);

      // Decimal 255: busy 9 cycles, commit at edge 9.
      strobe(8'd255, 1'b1);
      check("d255_busy_e0", 32'(bus.busy), 32'd1);
      repeat (7) tick();
      check("d255_busy_e7", 32'(bus.busy), 32'd1);
      tick();
      check("d255_busy_e8", 32'(bus.busy), 32'd1);
      check("d255_bcd_e8", 32'(bus.bcd), 32'h000);
      tick();
      check("d255_busy_e9", 32'(bus.busy), 32'd0);
      check("d255_bcd_e9", 32'(bus.bcd), 32'h255);
      check_digit("d255_d0", 1'b0, 3'b001, 7'h6D);
      check_digit("d255_d1", 1'b0, 3'b010, 7'h6D);
      check_digit("d255_d2", 1'b0, 3'b100, 7'h5B);

      // Each digit held SCAN_DIV cycles.
      n = 0;
      while (bus.dig_sel == 3'b010 && n < 20) begin tick(); n++; end
      n = 0;
      while (bus.dig_sel != 3'b010 && n < 20) begin tick(); n++; end
      n = 0;
      while (bus.dig_sel == 3'b010 && n < 20) begin tick(); n++; end
      check("scan_hold", 32'(n), 32'd4);

      // Hex 3C: commit at edge 1, d2 blank in both instances.
      strobe(8'h3C, 1'b0);
      check("h3c_busy_e0", 32'(bus.busy), 32'd1);
      tick();
      check("h3c_busy_e1", 32'(bus.busy), 32'd0);
      check("h3c_bcd_e1", 32'(bus.bcd), 32'h03C);
      check_digit("h3c_d0", 1'b0, 3'b001, 7'h39);
      check_digit("h3c_d1", 1'b0, 3'b010, 7'h4F);
      check_digit("h3c_d2", 1'b0, 3'b100, 7'h00);
      check_digit("h3c_d2_nolz", 1'b1, 3'b100, 7'h00);

      // Decimal 7: leading-zero blanking only when enabled.
      strobe(8'd7, 1'b1);
      repeat (9) tick();
      check("d7_bcd", 32'(bus.bcd), 32'h007);
      check_digit("d7_d0", 1'b0, 3'b001, 7'h07);
      check_digit("d7_d1", 1'b0, 3'b010, 7'h00);
      check_digit("d7_d2", 1'b0, 3'b100, 7'h00);
      check_digit("d7_d0_nolz", 1'b1, 3'b001, 7'h07);
      check_digit("d7_d1_nolz", 1'b1, 3'b010, 7'h3F);
      check_digit("d7_d2_nolz", 1'b1, 3'b100, 7'h3F);

      // 100, then 42 and 9 during busy: newest pending wins.
      strobe(8'd100, 1'b1);
      for (int e = 1; e <= 18; e++) begin
         if (e == 2) drive(1'b1, 8'd42, 1'b1);
         else if (e == 4) drive(1'b1, 8'd9, 1'b1);
         else drive(1'b0, 8'h00, 1'b0);
         tick();
         if (e == 9) check("pend_bcd_e9", 32'(bus.bcd), 32'h100);
         if (e == 17) check("pend_bcd_e17", 32'(bus.bcd), 32'h100);
         if (e == 5 || e == 9 || e == 10 || e == 17)
            check("pend_busy", 32'(bus.busy), 32'd1);
      end
      drive(1'b0, 8'h00, 1'b0);
      check("pend_bcd_e18", 32'(bus.bcd), 32'h009);
      check("pend_busy_e18", 32'(bus.busy), 32'd0);

      // Strobe on the commit edge with pend valid: live value wins, pend dropped.
      strobe(8'd200, 1'b1);
      for (int e = 1; e <= 18; e++) begin
         if (e == 3) drive(1'b1, 8'd50, 1'b1);
         else if (e == 9) drive(1'b1, 8'd77, 1'b1);
         else drive(1'b0, 8'h00, 1'b0);
         tick();
         if (e == 9) check("coll_bcd_e9", 32'(bus.bcd), 32'h200);
         if (e == 9) check("coll_busy_e9", 32'(bus.busy), 32'd1);
      end
      drive(1'b0, 8'h00, 1'b0);
      check("coll_bcd_e18", 32'(bus.bcd), 32'h077);
      check("coll_busy_e18", 32'(bus.busy), 32'd0);
      repeat (3) tick();
      check("coll_busy_after", 32'(bus.busy), 32'd0);
      check("coll_bcd_after", 32'(bus.bcd), 32'h077);

      // Reset mid-conversion.
      strobe(8'd123, 1'b1);
      repeat (4) tick();
      check("rst2_busy_pre", 32'(bus.busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("rst2_busy", 32'(bus.busy), 32'd0);
      check("rst2_bcd", 32'(bus.bcd), 32'h000);
      check("rst2_seg", 32'(bus.seg), 32'h00);
      check("rst2_sel", 32'(bus.dig_sel), 32'd0);
      check("rst2_sel0", 32'(bus0.dig_sel), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("rst2_post_sel", 32'(bus.dig_sel), 32'b001);
      check("rst2_post_seg", 32'(bus.seg), 32'h3F);
      strobe(8'd58, 1'b1);
      repeat (8) tick();
      check("rst2_d58_busy_e8", 32'(bus.busy), 32'd1);
      tick();
      check("rst2_d58_bcd", 32'(bus.bcd), 32'h058);
      check("rst2_d58_busy", 32'(bus.busy), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
